// File: rtl/dr_sched_if.sv
// Handshake and control bundle between dr_sched and its neighbours.
// The master side drives frame requests and upstream data-valid; the slave side is the sequencer.
interface dr_sched_if #(
  parameter int CW = 8
) ();
  logic          start;
  logic [CW-1:0] circ_len;
  logic          in_valid;
  logic          in_ready;
  logic          s0;
  logic          s1;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    frame_cnt;

  modport master (
    output start, circ_len, in_valid,
    input  in_ready, s0, s1, out_valid, busy, done, err, frame_cnt
  );

  modport slave (
    input  start, circ_len, in_valid,
    output in_ready, s0, s1, out_valid, busy, done, err, frame_cnt
  );
endinterface

// File: rtl/dr_sched.sv
// Frame sequencer for the recirculating delay register: fill, hold by recirculation, drain.
// All outputs are decoded from registered state only.
module dr_sched #(
  parameter int LONG  = 7,
  parameter int SHORT = 2,
  parameter int CW    = 8
) (
  input  logic        clk,
  input  logic        clear,
  dr_sched_if.slave   bus
);

  localparam int F     = LONG + SHORT;
  localparam int CNT_W = $clog2(F);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(F - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CIRC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    hcnt_q, hcnt_d;
  logic             err_q, err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FILL;
          cnt_d   = '0;
          hcnt_d  = bus.circ_len;
        end
      end
      FILL: begin
        if (!bus.in_valid) begin
          // A gap aborts the frame; the partial fill is simply overwritten by the next one.
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = (hcnt_q == '0) ? DRAIN : CIRC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CIRC: begin
        // Only entered with hcnt >= 1, so counting down to 1 never wraps for any circ_len.
        hcnt_d = hcnt_q - 1'b1;
        if (hcnt_q == CW'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously on the active-low reset.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    bus.s0        = 1'b0;
    bus.s1        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      FILL: begin
        bus.s0       = 1'b1;
        bus.s1       = 1'b1;
        bus.in_ready = 1'b1;
      end
      DRAIN: begin
        bus.s0        = 1'b1;
        bus.s1        = 1'b1;
        bus.out_valid = 1'b1;
        bus.done      = (cnt_q == LAST);
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dr_sched.sv
// Directed bench for dr_sched, driving a behavioural delay register from s0/s1
// so that drain order of the data samples is checked end to end.
module tb_dr_sched;

  logic       clk;
  logic       clear;
  logic [7:0] d;
  logic [7:0] a;
  logic [7:0] m [7];
  logic [7:0] x [2];
  int         cyc;
  int         checks;
  int         failures;

  dr_sched_if #(.CW(8)) bus ();

  dr_sched #(.LONG(7), .SHORT(2), .CW(8)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recirculating delay register: 7-stage main loop, 2-stage aux loop.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 7; i++) m[i] <= 8'd0;
      for (int i = 0; i < 2; i++) x[i] <= 8'd0;
    end else begin
      m[0] <= bus.s0 ? d : m[6];
      for (int i = 1; i < 7; i++) m[i] <= m[i-1];
      x[0] <= bus.s1 ? m[6] : x[1];
      x[1] <= x[0];
    end
  end
  assign a = bus.s1 ? x[1] : (bus.s0 ? d : m[6]);

  // {in_ready, s0, s1, out_valid, busy, done, err}
  function automatic logic [6:0] st();
    return {bus.in_ready, bus.s0, bus.s1, bus.out_valid, bus.busy, bus.done, bus.err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // One full frame: start, 9 fill samples base..base+8, cl hold cycles, 9 drain cycles.
  task automatic do_frame(input logic [7:0] cl, input logic [7:0] base,
                          input bit keep, input bit poke);
    int t0;
    t0       = cyc;
    start_pulse(cl);
    bus.start = keep;
    for (int i = 0; i < 9; i++) begin
      d            = base + 8'(i);
      bus.in_valid = 1'b1;
      check("fill_status", 32'(st()), 32'b1110100);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(cl); i++) begin
      if (poke) begin
        bus.start = (i == 1);
        if (i == 1) bus.circ_len = 8'd3;
      end
      check("circ_status", 32'(st()), 32'b0000100);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      if (poke) bus.start = (i == 2);
      check("drain_status", 32'(st()), (i == 8) ? 32'b0111110 : 32'b0111100);
      check("drain_data", 32'(a), 32'(base) + 32'(i));
      if (i == 8) check("start_to_done", 32'(cyc - t0), 32'd18 + 32'(cl));
      tick();
    end
  endtask

  task automatic start_pulse(input logic [7:0] cl);
    bus.start    = 1'b1;
    bus.circ_len = cl;
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    cyc          = 0;
    checks       = 0;
    failures     = 0;
    clear        = 1'b0;
    d            = 8'd0;
    bus.start    = 1'b0;
    bus.circ_len = 8'd0;
    bus.in_valid = 1'b0;

    #2;
    check("reset_status", 32'(st()), 32'd0);
    check("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    tick();
    check("idle_status", 32'(st()), 32'd0);

    // Order-preserving hold of 14, with start and circ_len poked mid-frame.
    do_frame(8'd14, 8'h10, 1'b0, 1'b1);
    check("frame_a_idle", 32'(st()), 32'd0);
    check("frame_a_cnt", 32'(bus.frame_cnt), 32'd1);

    // No hold: drain follows fill directly.
    do_frame(8'd0, 8'hA0, 1'b0, 1'b0);
    check("frame_b_cnt", 32'(bus.frame_cnt), 32'd2);

    // Fill abort on the 5th fill cycle.
    start_pulse(8'd5);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d            = 8'h20 + 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("abort_fill_status", 32'(st()), 32'b1110100);
    tick();
    check("abort_err_status", 32'(st()), 32'b0000001);
    check("abort_frame_cnt", 32'(bus.frame_cnt), 32'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_idle_status", 32'(st()), 32'd0);
    end

    do_frame(8'd14, 8'h30, 1'b0, 1'b0);
    check("retry_cnt", 32'(bus.frame_cnt), 32'd3);

    // Back-to-back frames with start held high, up to and across the counter wrap.
    for (int k = 0; k < 252; k++) do_frame(8'd0, 8'h40, 1'b1, 1'b0);
    check("b2b_cnt_255", 32'(bus.frame_cnt), 32'd255);
    do_frame(8'd0, 8'h40, 1'b0, 1'b0);
    check("b2b_cnt_wrap", 32'(bus.frame_cnt), 32'd0);
    check("b2b_idle_status", 32'(st()), 32'd0);

    // Asynchronous clear in the middle of DRAIN.
    start_pulse(8'd0);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d            = 8'h50 + 8'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pre_clear_data", 32'(a), 32'h50 + 32'(i));
      tick();
    end
    check("pre_clear_status", 32'(st()), 32'b0111100);
    #1;
    clear = 1'b0;
    #1;
    check("mid_clear_status", 32'(st()), 32'd0);
    check("mid_clear_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_clear_status", 32'(st()), 32'd0);
    clear = 1'b1;
    tick();

    do_frame(8'd28, 8'h60, 1'b0, 1'b0);
    check("post_clear_cnt", 32'(bus.frame_cnt), 32'd1);
    check("post_clear_status", 32'(st()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
